scariv_disp_grp_receiver: RTL and testbench

- Slave-side receiver for a dispatch group: accepts one group per valid/ready handshake and buffers it in a small group FIFO.
- Serializes the slots that target this scheduler into a one-instruction-per-cycle valid/ready stream toward an issue queue.
- Sits between the rename/dispatch stage and a single scheduler (ALU/LSU/BRU).
- Flags resource-count mismatches and supports pipeline flush.

---
 rtl/scariv_disp_grp_receiver_if.sv | 33 +++
 rtl/scariv_disp_grp_receiver.sv | 153 +++++++++++++++
 tb/tb_scariv_disp_grp_receiver.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scariv_disp_grp_receiver_if.sv
// Handshake bundle between the dispatch stage, the group receiver and the issue queue.
// The slave modport is the receiver's view; the master modport is the surrounding logic's view.
interface scariv_disp_grp_receiver_if #(
    parameter int DISP_SIZE = 5,
    parameter int INST_W    = 64,
    parameter int CMT_ID_W  = 6,
    parameter int RES_W     = $clog2(DISP_SIZE + 1),
    parameter int GRP_ID_W  = $clog2(DISP_SIZE)
);
    logic                        i_disp_valid;
    logic                        o_disp_ready;
    logic [CMT_ID_W-1:0]         i_disp_cmt_id;
    logic [DISP_SIZE-1:0]        i_disp_grp_valid;
    logic [RES_W-1:0]            i_disp_res_cnt;
    logic [DISP_SIZE*INST_W-1:0] i_disp_inst;

    logic                        o_out_valid;
    logic                        i_out_ready;
    logic [CMT_ID_W-1:0]         o_out_cmt_id;
    logic [GRP_ID_W-1:0]         o_out_grp_id;
    logic [INST_W-1:0]           o_out_inst;
    logic                        o_out_last;

    modport slave (
        input  i_disp_valid, i_disp_cmt_id, i_disp_grp_valid, i_disp_res_cnt, i_disp_inst, i_out_ready,
        output o_disp_ready, o_out_valid, o_out_cmt_id, o_out_grp_id, o_out_inst, o_out_last
    );

    modport master (
        output i_disp_valid, i_disp_cmt_id, i_disp_grp_valid, i_disp_res_cnt, i_disp_inst, i_out_ready,
        input  o_disp_ready, o_out_valid, o_out_cmt_id, o_out_grp_id, o_out_inst, o_out_last
    );
endinterface

// File: rtl/scariv_disp_grp_receiver.sv
// Dispatch-group receiver: buffers accepted groups and serializes their selected slots toward one issue queue.
// Defining SCARIV_DISP_RECV_PERF_EN adds saturating full-stall / output-stall counters.
module scariv_disp_grp_receiver #(
    parameter int DISP_SIZE = 5,
    parameter int INST_W    = 64,
    parameter int CMT_ID_W  = 6,
    parameter int GRP_DEPTH = 2,
    parameter int RES_W     = $clog2(DISP_SIZE + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    scariv_disp_grp_receiver_if.slave  recv_if,
    output logic                       o_res_err
`ifdef SCARIV_DISP_RECV_PERF_EN
    ,
    output logic [31:0]                o_perf_full_stall,
    output logic [31:0]                o_perf_out_stall
`endif
);
    localparam int GRP_ID_W = $clog2(DISP_SIZE);
    localparam int PTR_W    = $clog2(GRP_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic [CMT_ID_W-1:0]         r_cmt_id    [GRP_DEPTH];
    logic [DISP_SIZE-1:0]        r_grp_valid [GRP_DEPTH];
    logic [DISP_SIZE*INST_W-1:0] r_inst      [GRP_DEPTH];

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [DISP_SIZE-1:0] r_mask;
    logic                 r_res_err;

    logic                 w_disp_ready;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_res_mismatch;
    logic                 w_out_valid;
    logic [DISP_SIZE-1:0] w_low;
    logic                 w_last;
    logic                 w_fire;
    logic                 w_pop;
    logic [PTR_W-1:0]     w_rd_next;
    logic [GRP_ID_W-1:0]  w_grp_id;
    logic [INST_W-1:0]    w_slot_inst;

    assign w_disp_ready   = !i_reset && !i_flush && (r_count < CNT_W'(GRP_DEPTH));
    assign w_accept       = recv_if.i_disp_valid && w_disp_ready;
    assign w_push         = w_accept && (|recv_if.i_disp_grp_valid);
    assign w_res_mismatch = RES_W'($countones(recv_if.i_disp_grp_valid)) != recv_if.i_disp_res_cnt;

    // The head entry's remaining mask is non-zero whenever the FIFO holds anything.
    assign w_out_valid = (r_count != '0);
    assign w_low       = r_mask & (~r_mask + DISP_SIZE'(1));
    assign w_last      = w_out_valid && ((r_mask & (r_mask - DISP_SIZE'(1))) == '0);
    assign w_fire      = w_out_valid && recv_if.i_out_ready;
    assign w_pop       = w_fire && w_last;
    assign w_rd_next   = r_rd_ptr + PTR_W'(1);

    always_comb begin
        w_grp_id    = '0;
        w_slot_inst = '0;
        for (int i = 0; i < DISP_SIZE; i++) begin
            if (w_low[i]) begin
                w_grp_id    = GRP_ID_W'(i);
                w_slot_inst = r_inst[r_rd_ptr][i*INST_W +: INST_W];
            end
        end
    end

    assign recv_if.o_disp_ready = w_disp_ready;
    assign recv_if.o_out_valid  = w_out_valid;
    assign recv_if.o_out_cmt_id = w_out_valid ? r_cmt_id[r_rd_ptr] : '0;
    assign recv_if.o_out_grp_id = w_out_valid ? w_grp_id : '0;
    assign recv_if.o_out_inst   = w_out_valid ? w_slot_inst : '0;
    assign recv_if.o_out_last   = w_last;
    assign o_res_err            = r_res_err;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_cmt_id[r_wr_ptr]    <= recv_if.i_disp_cmt_id;
            r_grp_valid[r_wr_ptr] <= recv_if.i_disp_grp_valid;
            r_inst[r_wr_ptr]      <= recv_if.i_disp_inst;
        end
    end

    // On the last slot the next head's mask loads in the same edge, so groups stream without a bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_mask    <= '0;
            r_res_err <= 1'b0;
        end else begin
            if (w_accept && w_res_mismatch) begin
                r_res_err <= 1'b1;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_mask   <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_next;
                    if (r_count > CNT_W'(1)) begin
                        r_mask <= r_grp_valid[w_rd_next];
                    end else if (w_push) begin
                        r_mask <= recv_if.i_disp_grp_valid;
                    end else begin
                        r_mask <= '0;
                    end
                end else if (w_fire) begin
                    r_mask <= r_mask & ~w_low;
                end else if (w_push && (r_count == '0)) begin
                    r_mask <= recv_if.i_disp_grp_valid;
                end
            end
        end
    end

`ifdef SCARIV_DISP_RECV_PERF_EN
    logic [31:0] r_perf_full_stall;
    logic [31:0] r_perf_out_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_full_stall <= '0;
            r_perf_out_stall  <= '0;
        end else begin
            if (recv_if.i_disp_valid && !w_disp_ready && !i_flush && (r_perf_full_stall != '1)) begin
                r_perf_full_stall <= r_perf_full_stall + 32'd1;
            end
            if (w_out_valid && !recv_if.i_out_ready && (r_perf_out_stall != '1)) begin
                r_perf_out_stall <= r_perf_out_stall + 32'd1;
            end
        end
    end

    assign o_perf_full_stall = r_perf_full_stall;
    assign o_perf_out_stall  = r_perf_out_stall;
`endif
endmodule

// File: tb/tb_scariv_disp_grp_receiver.sv
// Testbench for scariv_disp_grp_receiver: directed vector table, corner sequences and random traffic
// checked every cycle against a queue-of-groups reference model.
module tb_scariv_disp_grp_receiver;
    localparam int DS = 5;
    localparam int IW = 64;
    localparam int CW = 6;
    localparam int GD = 2;
    localparam int RW = 3;
    localparam int GW = 3;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic resErr;
`ifdef SCARIV_DISP_RECV_PERF_EN
    logic [31:0] perfFull;
    logic [31:0] perfOut;
`endif

    always #5 clk = ~clk;

    scariv_disp_grp_receiver_if #(.DISP_SIZE(DS), .INST_W(IW), .CMT_ID_W(CW), .RES_W(RW), .GRP_ID_W(GW)) dif ();

    scariv_disp_grp_receiver #(.DISP_SIZE(DS), .INST_W(IW), .CMT_ID_W(CW), .GRP_DEPTH(GD), .RES_W(RW)) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_flush           (flush),
        .recv_if           (dif),
        .o_res_err         (resErr)
`ifdef SCARIV_DISP_RECV_PERF_EN
        ,
        .o_perf_full_stall (perfFull),
        .o_perf_out_stall  (perfOut)
`endif
    );

    typedef struct packed {
        logic [CW-1:0]    cmt;
        logic [DS-1:0]    mask;
        logic [DS*IW-1:0] inst;
    } grp_t;

    typedef struct packed {
        bit            rst;
        bit            valid;
        bit            flush;
        bit            oready;
        logic [CW-1:0] cmt;
        logic [DS-1:0] grp;
        logic [RW-1:0] res;
    } stim_t;

    typedef struct packed {
        stim_t         s;
        bit            eReady;
        bit            eValid;
        bit            eLast;
        bit            eErr;
        logic [GW-1:0] eSlot;
        logic [CW-1:0] eCmt;
    } vec_t;

    grp_t        mq[$];
    bit          mErr;
    int unsigned mFull;
    int unsigned mOut;
    int          total = 0;
    int          bad   = 0;

    logic          dutReady;
    logic          dutValid;
    logic [CW-1:0] dutCmt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t st(input bit r, input bit v, input bit f, input bit o,
                                 input int c, input int g, input int rs);
        stim_t x;
        x.rst    = r;
        x.valid  = v;
        x.flush  = f;
        x.oready = o;
        x.cmt    = CW'(c);
        x.grp    = DS'(g);
        x.res    = RW'(rs);
        return x;
    endfunction

    function automatic vec_t vec(input stim_t s, input bit r, input bit v, input bit l,
                                 input bit e, input int slot, input int c);
        vec_t x;
        x.s      = s;
        x.eReady = r;
        x.eValid = v;
        x.eLast  = l;
        x.eErr   = e;
        x.eSlot  = GW'(slot);
        x.eCmt   = CW'(c);
        return x;
    endfunction

    function automatic int lowest(input logic [DS-1:0] m);
        for (int i = 0; i < DS; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit modelReady(input stim_t s);
        return !s.rst && !s.flush && (mq.size() < GD);
    endfunction

    // Compare every DUT output with what the model predicts for the current cycle.
    task automatic checkOutput(input stim_t s);
        grp_t h;
        int   slot;
        chk("disp_ready", 64'(dif.o_disp_ready), 64'(modelReady(s)));
        chk("out_valid", 64'(dif.o_out_valid), 64'(mq.size() > 0));
        chk("res_err", 64'(resErr), 64'(mErr));
        if (mq.size() > 0) begin
            h    = mq[0];
            slot = lowest(h.mask);
            chk("out_cmt_id", 64'(dif.o_out_cmt_id), 64'(h.cmt));
            chk("out_grp_id", 64'(dif.o_out_grp_id), 64'(slot));
            chk("out_last", 64'(dif.o_out_last), 64'($countones(h.mask) == 1));
            chk("out_inst", dif.o_out_inst, h.inst[slot*IW +: IW]);
        end
`ifdef SCARIV_DISP_RECV_PERF_EN
        chk("perf_full_stall", 64'(perfFull), 64'(mFull));
        chk("perf_out_stall", 64'(perfOut), 64'(mOut));
`endif
    endtask

    task automatic updateModel(input stim_t s, input logic [DS*IW-1:0] inst);
        grp_t h;
        bit   rdy;
        bit   vld;
        if (s.rst) begin
            mq.delete();
            mErr  = 1'b0;
            mFull = 0;
            mOut  = 0;
        end else begin
            rdy = modelReady(s);
            vld = mq.size() > 0;
            if (s.valid && !rdy && !s.flush) mFull++;
            if (vld && !s.oready) mOut++;
            if (vld && s.oready) begin
                h = mq.pop_front();
                h.mask[lowest(h.mask)] = 1'b0;
                if (h.mask != '0) mq.push_front(h);
            end
            if (s.flush) mq.delete();
            if (s.valid && rdy) begin
                if ($countones(s.grp) != int'(s.res)) mErr = 1'b1;
                if (s.grp != '0) begin
                    h.cmt  = s.cmt;
                    h.mask = s.grp;
                    h.inst = inst;
                    mq.push_back(h);
                end
            end
        end
    endtask

    logic [DS*IW-1:0] curInst;
    stim_t            curStim;

    task automatic driveInputs(input stim_t s);
        @(negedge clk);
        for (int k = 0; k < (DS*IW)/32; k++) curInst[k*32 +: 32] = $urandom;
        curStim               = s;
        rst                   = s.rst;
        flush                 = s.flush;
        dif.i_disp_valid      = s.valid;
        dif.i_disp_cmt_id     = s.cmt;
        dif.i_disp_grp_valid  = s.grp;
        dif.i_disp_res_cnt    = s.res;
        dif.i_disp_inst       = curInst;
        dif.i_out_ready       = s.oready;
        #1;
        dutReady = dif.o_disp_ready;
        dutValid = dif.o_out_valid;
        dutCmt   = dif.o_out_cmt_id;
        checkOutput(s);
    endtask

    task automatic advance();
        @(posedge clk);
        updateModel(curStim, curInst);
    endtask

    task automatic applyStimulus(input stim_t s);
        driveInputs(s);
        advance();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t  tbl[12];
        stim_t idle;
        stim_t s;
        int    k;
        int    cyc;
        int    acceptCyc;
        int    nNew;

        rst                  = 1'b1;
        flush                = 1'b0;
        dif.i_disp_valid     = 1'b0;
        dif.i_disp_cmt_id    = '0;
        dif.i_disp_grp_valid = '0;
        dif.i_disp_res_cnt   = '0;
        dif.i_disp_inst      = '0;
        dif.i_out_ready      = 1'b0;
        mq.delete();
        mErr  = 1'b0;
        mFull = 0;
        mOut  = 0;
        curStim = st(1, 0, 0, 0, 0, 0, 0);
        curInst = '0;
        repeat (2) @(posedge clk);

        @(negedge clk);
        chk("reset_disp_ready", 64'(dif.o_disp_ready), 64'(0));
        chk("reset_out_valid", 64'(dif.o_out_valid), 64'(0));
        chk("reset_res_err", 64'(resErr), 64'(0));
        chk("reset_out_cmt_id", 64'(dif.o_out_cmt_id), 64'(0));
        chk("reset_out_inst", dif.o_out_inst, 64'(0));
        chk("reset_out_last", 64'(dif.o_out_last), 64'(0));

        idle = st(0, 0, 0, 1, 0, 0, 0);
        tbl[0]  = vec(st(0, 1, 0, 1, 3, 5'b10110, 2),  1, 0, 0, 0, 0, 0);
        tbl[1]  = vec(idle,                            1, 1, 0, 1, 1, 3);
        tbl[2]  = vec(idle,                            1, 1, 0, 1, 2, 3);
        tbl[3]  = vec(idle,                            1, 1, 1, 1, 4, 3);
        tbl[4]  = vec(idle,                            1, 0, 0, 1, 0, 0);
        tbl[5]  = vec(st(1, 0, 0, 1, 0, 0, 0),         0, 0, 0, 1, 0, 0);
        tbl[6]  = vec(st(1, 0, 0, 1, 0, 0, 0),         0, 0, 0, 0, 0, 0);
        tbl[7]  = vec(st(0, 1, 0, 1, 10, 5'b00011, 2), 1, 0, 0, 0, 0, 0);
        tbl[8]  = vec(st(0, 1, 0, 1, 11, 5'b00001, 1), 1, 1, 0, 0, 0, 10);
        tbl[9]  = vec(idle,                            0, 1, 1, 0, 1, 10);
        tbl[10] = vec(idle,                            1, 1, 1, 0, 0, 11);
        tbl[11] = vec(idle,                            1, 0, 0, 0, 0, 0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            driveInputs(tbl[i].s);
            chk($sformatf("tbl%0d_ready", i), 64'(dif.o_disp_ready), 64'(tbl[i].eReady));
            chk($sformatf("tbl%0d_valid", i), 64'(dif.o_out_valid), 64'(tbl[i].eValid));
            chk($sformatf("tbl%0d_err", i), 64'(resErr), 64'(tbl[i].eErr));
            if (tbl[i].eValid) begin
                chk($sformatf("tbl%0d_slot", i), 64'(dif.o_out_grp_id), 64'(tbl[i].eSlot));
                chk($sformatf("tbl%0d_last", i), 64'(dif.o_out_last), 64'(tbl[i].eLast));
                chk($sformatf("tbl%0d_cmt", i), 64'(dif.o_out_cmt_id), 64'(tbl[i].eCmt));
            end
            advance();
        end

        $display("[TB] full FIFO sequence");
        k         = 0;
        cyc       = 0;
        acceptCyc = -1;
        while (k < 3 && cyc < 20) begin
            s = st(0, 1, 0, (cyc >= 6), 20 + k, 5'b00001, 1);
            driveInputs(s);
            if (dutReady) begin
                k++;
                if (k == 3) acceptCyc = cyc;
            end
            advance();
            cyc++;
        end
        chk("full_accept_count", 64'(k), 64'(3));
        chk("full_third_accept_cycle", 64'(acceptCyc), 64'(7));
        repeat (4) applyStimulus(idle);

        $display("[TB] flush sequence");
        applyStimulus(st(0, 1, 0, 0, 30, 5'b10101, 3));
        applyStimulus(st(0, 1, 0, 0, 31, 5'b00111, 3));
        applyStimulus(st(0, 0, 0, 1, 0, 0, 0));
        applyStimulus(st(0, 1, 1, 1, 32, 5'b00001, 1));
        driveInputs(st(0, 1, 0, 1, 9, 5'b11001, 3));
        chk("flush_out_valid", 64'(dutValid), 64'(0));
        chk("flush_ready", 64'(dutReady), 64'(1));
        advance();
        nNew = 0;
        for (int i = 0; i < 5; i++) begin
            driveInputs(idle);
            if (dutValid && dutCmt == CW'(9)) nNew++;
            advance();
        end
        chk("flush_new_group_outputs", 64'(nNew), 64'(3));

        $display("[TB] empty group sequence");
        applyStimulus(st(1, 0, 0, 1, 0, 0, 0));
        applyStimulus(st(1, 0, 0, 1, 0, 0, 0));
        applyStimulus(st(0, 1, 0, 1, 12, 0, 0));
        repeat (2) applyStimulus(idle);
        driveInputs(idle);
        chk("empty_no_output", 64'(dutValid), 64'(0));
        chk("empty_res_err", 64'(resErr), 64'(0));
        advance();
`ifdef SCARIV_DISP_RECV_PERF_EN
        applyStimulus(st(0, 1, 0, 0, 13, 5'b00001, 1));
        applyStimulus(st(0, 1, 0, 0, 14, 5'b00001, 1));
        repeat (3) applyStimulus(st(0, 1, 0, 0, 15, 5'b00001, 1));
        driveInputs(st(0, 0, 0, 0, 0, 0, 0));
        chk("perf_full_stall_three", 64'(perfFull), 64'(3));
        advance();
        applyStimulus(st(1, 0, 0, 1, 0, 0, 0));
        applyStimulus(st(1, 0, 0, 1, 0, 0, 0));
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            int g;
            int r;
            g = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : $countones(DS'(g));
            s = st(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 9) < 7), int'($urandom_range(0, 63)), g, r);
            applyStimulus(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
